// File: rtl/pipectrl32_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state codes, forwarding
// select codes, scoreboard layout and entry field widths.
// Optional feature macro used by this slice: PIPECTRL_FWD_EN.
package pipectrl32_pkg;

    // Default register address width of the core
    localparam int unsigned DEF_REGAW = 4;

    // Scoreboard layout: index 0 is the youngest stage
    localparam int unsigned SB_DEPTH = 3;
    localparam int unsigned SB_EX    = 0;
    localparam int unsigned SB_MEM   = 1;
    localparam int unsigned SB_WB    = 2;

    // Scoreboard entry field widths (rd width is REGAW)
    localparam int unsigned SB_VALID_W = 1;
    localparam int unsigned SB_WE_W    = 1;
    localparam int unsigned SB_LOAD_W  = 1;
    localparam int unsigned SB_FLAGS_W = 1;

    // Flush countdown width, enough for BRANCH_BUBBLES up to 7
    localparam int unsigned FCNTW = 3;

    // Sequencer states
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    // Operand source select codes
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Map a scoreboard index to its forwarding select code
    function automatic logic [1:0] stage_sel(input int unsigned idx);
        return 2'(idx + 1);
    endfunction

endpackage

// File: rtl/pipectrl32_hazcmp.sv
// Compares one decode source register against the three scoreboard entries
// and reports whether any live writer matches and which is the youngest.
module pipectrl32_hazcmp
    import pipectrl32_pkg::*;
#(
    parameter int unsigned REGAW = DEF_REGAW
) (
    input  logic [REGAW-1:0]    src,
    input  logic                src_used,
    input  logic [SB_DEPTH-1:0] wr_live,   // per entry: valid & we, bit 0 = EX
    input  logic [REGAW-1:0]    rd_ex,
    input  logic [REGAW-1:0]    rd_mem,
    input  logic [REGAW-1:0]    rd_wb,
    output logic                hit,
    output logic [1:0]          sel
);

    logic [SB_DEPTH-1:0] match;

    // Per-entry match, then youngest-wins select (EX checked last so it overrides)
    always_comb begin
        match        = '0;
        match[SB_EX]  = src_used && wr_live[SB_EX]  && (src == rd_ex);
        match[SB_MEM] = src_used && wr_live[SB_MEM] && (src == rd_mem);
        match[SB_WB]  = src_used && wr_live[SB_WB]  && (src == rd_wb);
        hit = |match;
        sel = FWD_RF;
        if (match[SB_WB])  sel = stage_sel(SB_WB);
        if (match[SB_MEM]) sel = stage_sel(SB_MEM);
        if (match[SB_EX])  sel = stage_sel(SB_EX);
    end

endmodule

// File: rtl/pipectrl32.sv
// Pipeline sequencer for the 32-bit core. Tracks in-flight writers in
// EX/MEM/WB, detects RAW and flag hazards against decode, and drives
// stall/bubble/flush, the decoder's previous-was-branch input and a
// saturating stall counter.
// Optional feature macro: PIPECTRL_FWD_EN (operand forwarding selects).
module pipectrl32
    import pipectrl32_pkg::*;
#(
    parameter int unsigned REGAW          = DEF_REGAW,
    parameter int unsigned BRANCH_BUBBLES = 2,
    parameter int unsigned CNTW           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REGAW-1:0] dec_rn,
    input  logic [REGAW-1:0] dec_rm,
    input  logic [REGAW-1:0] dec_rd,
    input  logic             dec_uses_rn,
    input  logic             dec_uses_rm,
    input  logic             dec_reg_we,
    input  logic             dec_is_load,
    input  logic             dec_sets_flags,
    input  logic             dec_is_cond,
    input  logic             dec_ib,
    output logic             stall_out,
    output logic             bubble_out,
    output logic             flush_out,
    output logic             ispb_out,
`ifdef PIPECTRL_FWD_EN
    output logic [1:0]       fwd_rn_sel,
    output logic [1:0]       fwd_rm_sel,
`endif
    output logic [CNTW-1:0]  stall_cnt_out
);

    // Scoreboard, index 0 = EX, 1 = MEM, 2 = WB
    logic [SB_DEPTH-1:0] sb_valid_q, sb_valid_d;
    logic [SB_DEPTH-1:0] sb_we_q,    sb_we_d;
    logic [SB_DEPTH-1:0] sb_load_q,  sb_load_d;
    logic [SB_DEPTH-1:0] sb_flags_q, sb_flags_d;
    logic [REGAW-1:0]    sb_rd_q [SB_DEPTH];
    logic [REGAW-1:0]    sb_rd_d [SB_DEPTH];

    state_e           state_q, state_d;
    logic [FCNTW-1:0] fcnt_q, fcnt_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic                in_flush;
    logic [SB_DEPTH-1:0] wr_live;
    logic                rn_hit, rm_hit;
    logic [1:0]          rn_sel, rm_sel;
    logic                raw_haz, flag_haz, hazard, issue;

    assign in_flush = (state_q == StFlush);
    assign wr_live  = sb_valid_q & sb_we_q;

    pipectrl32_hazcmp #(
        .REGAW (REGAW)
    ) u_hazcmp_rn (
        .src      (dec_rn),
        .src_used (dec_uses_rn),
        .wr_live  (wr_live),
        .rd_ex    (sb_rd_q[SB_EX]),
        .rd_mem   (sb_rd_q[SB_MEM]),
        .rd_wb    (sb_rd_q[SB_WB]),
        .hit      (rn_hit),
        .sel      (rn_sel)
    );

    pipectrl32_hazcmp #(
        .REGAW (REGAW)
    ) u_hazcmp_rm (
        .src      (dec_rm),
        .src_used (dec_uses_rm),
        .wr_live  (wr_live),
        .rd_ex    (sb_rd_q[SB_EX]),
        .rd_mem   (sb_rd_q[SB_MEM]),
        .rd_wb    (sb_rd_q[SB_WB]),
        .hit      (rm_hit),
        .sel      (rm_sel)
    );

`ifdef PIPECTRL_FWD_EN
    // Only a load still sitting in EX cannot be forwarded yet
    assign raw_haz = (rn_hit && (rn_sel == FWD_EX) && sb_load_q[SB_EX]) ||
                     (rm_hit && (rm_sel == FWD_EX) && sb_load_q[SB_EX]);
    assign fwd_rn_sel = rn_sel;
    assign fwd_rm_sel = rm_sel;
`else
    // WB still conflicts: the register file writes at the end of WB
    assign raw_haz = rn_hit || rm_hit;

    logic unused_fwd;
    assign unused_fwd = ^{rn_sel, rm_sel, sb_load_q};
`endif

    assign flag_haz = dec_is_cond && |(sb_valid_q & sb_flags_q);
    assign hazard   = dec_valid && (raw_haz || flag_haz) && !in_flush;
    assign issue    = dec_valid && !hazard && !in_flush;

    assign stall_out     = hazard;
    assign bubble_out    = hazard;
    assign flush_out     = in_flush;
    assign ispb_out      = in_flush;
    assign stall_cnt_out = cnt_q;

    // Scoreboard shift: EX takes the issuing instruction or an empty slot
    always_comb begin
        sb_valid_d = '0;
        sb_we_d    = '0;
        sb_load_d  = '0;
        sb_flags_d = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            sb_rd_d[i] = '0;
        end
        for (int i = 1; i < SB_DEPTH; i++) begin
            sb_valid_d[i] = sb_valid_q[i-1];
            sb_we_d[i]    = sb_we_q[i-1];
            sb_load_d[i]  = sb_load_q[i-1];
            sb_flags_d[i] = sb_flags_q[i-1];
            sb_rd_d[i]    = sb_rd_q[i-1];
        end
        if (issue) begin
            sb_valid_d[SB_EX] = 1'b1;
            sb_we_d[SB_EX]    = dec_reg_we;
            sb_load_d[SB_EX]  = dec_is_load;
            sb_flags_d[SB_EX] = dec_sets_flags;
            sb_rd_d[SB_EX]    = dec_rd;
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_q <= '0;
            sb_we_q    <= '0;
            sb_load_q  <= '0;
            sb_flags_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_rd_q[i] <= '0;
            end
        end else begin
            sb_valid_q <= sb_valid_d;
            sb_we_q    <= sb_we_d;
            sb_load_q  <= sb_load_d;
            sb_flags_q <= sb_flags_d;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_rd_q[i] <= sb_rd_d[i];
            end
        end
    end

    // Sequencer next state: a stalled branch enters FLUSH only when it issues
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StRun, StStall: begin
                if (hazard) begin
                    state_d = StStall;
                end else if (issue && dec_ib) begin
                    state_d = StFlush;
                    fcnt_d  = FCNTW'(BRANCH_BUBBLES - 1);
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (fcnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    fcnt_d = fcnt_q - FCNTW'(1);
                end
            end
            default: begin
                state_d = StRun;
                fcnt_d  = '0;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Saturating stall counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (stall_out && !(&cnt_q)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipectrl32.sv
// Self-checking bench for pipectrl32: directed vector table plus hand-written
// multi-cycle sequences (forwarding, mid-FLUSH reset, counter saturation).
module tb_pipectrl32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       dec_valid;
    logic [3:0] dec_rn, dec_rm, dec_rd;
    logic       dec_uses_rn, dec_uses_rm, dec_reg_we, dec_is_load;
    logic       dec_sets_flags, dec_is_cond, dec_ib;
    logic       stall_out, bubble_out, flush_out, ispb_out;
    logic [15:0] stall_cnt_out;
    logic       sat_stall, sat_bubble, sat_flush, sat_ispb;
    logic [7:0] sat_cnt;
`ifdef PIPECTRL_FWD_EN
    logic [1:0] fwd_rn_sel, fwd_rm_sel, sat_fwd_rn, sat_fwd_rm;
`endif

    pipectrl32 #(
        .REGAW          (4),
        .BRANCH_BUBBLES (2),
        .CNTW           (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_valid      (dec_valid),
        .dec_rn         (dec_rn),
        .dec_rm         (dec_rm),
        .dec_rd         (dec_rd),
        .dec_uses_rn    (dec_uses_rn),
        .dec_uses_rm    (dec_uses_rm),
        .dec_reg_we     (dec_reg_we),
        .dec_is_load    (dec_is_load),
        .dec_sets_flags (dec_sets_flags),
        .dec_is_cond    (dec_is_cond),
        .dec_ib         (dec_ib),
        .stall_out      (stall_out),
        .bubble_out     (bubble_out),
        .flush_out      (flush_out),
        .ispb_out       (ispb_out),
`ifdef PIPECTRL_FWD_EN
        .fwd_rn_sel     (fwd_rn_sel),
        .fwd_rm_sel     (fwd_rm_sel),
`endif
        .stall_cnt_out  (stall_cnt_out)
    );

    // Narrow-counter copy sharing the stimulus, so saturation is reachable quickly
    pipectrl32 #(
        .REGAW          (4),
        .BRANCH_BUBBLES (2),
        .CNTW           (8)
    ) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_valid      (dec_valid),
        .dec_rn         (dec_rn),
        .dec_rm         (dec_rm),
        .dec_rd         (dec_rd),
        .dec_uses_rn    (dec_uses_rn),
        .dec_uses_rm    (dec_uses_rm),
        .dec_reg_we     (dec_reg_we),
        .dec_is_load    (dec_is_load),
        .dec_sets_flags (dec_sets_flags),
        .dec_is_cond    (dec_is_cond),
        .dec_ib         (dec_ib),
        .stall_out      (sat_stall),
        .bubble_out     (sat_bubble),
        .flush_out      (sat_flush),
        .ispb_out       (sat_ispb),
`ifdef PIPECTRL_FWD_EN
        .fwd_rn_sel     (sat_fwd_rn),
        .fwd_rm_sel     (sat_fwd_rm),
`endif
        .stall_cnt_out  (sat_cnt)
    );

    typedef struct {
        logic       valid;
        logic [3:0] rn, rm, rd;
        logic       urn, urm, we, ld, sf, cond, ib;
        logic       e_stall, e_flush;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    vec_t vq[$];

    function automatic vec_t mk(input logic valid, input int rn, input int rm, input int rd,
                                input logic urn, input logic urm, input logic we,
                                input logic ld, input logic sf, input logic cond,
                                input logic ib, input logic e_stall, input logic e_flush);
        vec_t v;
        v.valid = valid; v.rn = 4'(rn); v.rm = 4'(rm); v.rd = 4'(rd);
        v.urn = urn; v.urm = urm; v.we = we; v.ld = ld; v.sf = sf;
        v.cond = cond; v.ib = ib; v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        dec_valid = v.valid; dec_rn = v.rn; dec_rm = v.rm; dec_rd = v.rd;
        dec_uses_rn = v.urn; dec_uses_rm = v.urm; dec_reg_we = v.we;
        dec_is_load = v.ld; dec_sets_flags = v.sf; dec_is_cond = v.cond; dec_ib = v.ib;
    endtask

    // Drive a row, compare at the falling edge; leaves time at the falling edge
    task automatic drive_check(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        chk({name, " stall"}, 32'(stall_out), 32'(v.e_stall));
        chk({name, " bubble"}, 32'(bubble_out), 32'(v.e_stall));
        chk({name, " flush"}, 32'(flush_out), 32'(v.e_flush));
        chk({name, " ispb"}, 32'(ispb_out), 32'(v.e_flush));
        if (v.e_stall) exp_cnt++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input string name);
        drive_check(v, name);
        adv();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(idle());
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall_out), 0);
        chk("reset bubble", 32'(bubble_out), 0);
        chk("reset flush", 32'(flush_out), 0);
        chk("reset ispb", 32'(ispb_out), 0);
        chk("reset cnt", 32'(stall_cnt_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();

        // ADD r1,r2,r3 then SUB r2,r1,r3
        step(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), "add");
`ifdef PIPECTRL_FWD_EN
        drive_check(mk(1, 1, 3, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), "sub fwd");
        chk("sub fwd_rn_sel", 32'(fwd_rn_sel), 1);
        chk("sub fwd_rm_sel", 32'(fwd_rm_sel), 0);
        adv();
        chk("addsub cnt", 32'(stall_cnt_out), 0);
        repeat (3) step(idle(), "drain");
        // LDR r3,[r4] then ADD r4,r6,r3
        step(mk(1, 4, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0), "ldr");
        step(mk(1, 6, 3, 4, 1, 1, 1, 0, 0, 0, 0, 1, 0), "ldr-use stall");
        drive_check(mk(1, 6, 3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0), "ldr-use issue");
        chk("ldr-use fwd_rm_sel", 32'(fwd_rm_sel), 2);
        chk("ldr-use fwd_rn_sel", 32'(fwd_rn_sel), 0);
        adv();
        chk("ldr cnt", 32'(stall_cnt_out), 32'(exp_cnt));
`else
        repeat (3) step(mk(1, 1, 3, 2, 1, 1, 1, 0, 0, 0, 0, 1, 0), "sub stall");
        step(mk(1, 1, 3, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), "sub issue");
        chk("addsub cnt", 32'(stall_cnt_out), 3);
`endif
        repeat (3) step(idle(), "drain");

        // Hazard filtering: failed-condition producer, unused matching source
        vq.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 5, 0, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 6, 7, 13, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 6, 6, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) vq.push_back(idle());
        // CMP then conditional taken branch, junk during FLUSH, flag consumer after
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        repeat (3) vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        repeat (2) vq.push_back(mk(1, 9, 9, 9, 1, 1, 1, 0, 1, 1, 0, 0, 1));
        vq.push_back(mk(1, 9, 0, 11, 1, 0, 1, 0, 0, 1, 0, 0, 0));
        repeat (3) vq.push_back(idle());

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i], $sformatf("vec%0d", i));
        end
        chk("table cnt", 32'(stall_cnt_out), 32'(exp_cnt));

        // Reset during the first FLUSH cycle (fcnt=1)
        step(mk(1, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0), "prod r10");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "branch");
        drive(mk(1, 10, 0, 14, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("preflush flush", 32'(flush_out), 1);
        chk("preflush ispb", 32'(ispb_out), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst flush", 32'(flush_out), 0);
        chk("async rst ispb", 32'(ispb_out), 0);
        chk("async rst stall", 32'(stall_out), 0);
        chk("async rst cnt", 32'(stall_cnt_out), 0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        step(mk(1, 10, 0, 14, 1, 0, 1, 0, 0, 0, 0, 0, 0), "post-rst r10");
        repeat (3) step(idle(), "drain");

        // Back-to-back flag-setting conditionals: 3 stalls per 4 cycles
        for (int i = 0; i < 400; i++) begin
            step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, (i % 4) != 0, 0), "sat");
        end
        chk("sat cnt8", 32'(sat_cnt), 32'hff);
        chk("sat cnt16", 32'(stall_cnt_out), 32'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time bound in case anything stops advancing
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
